// File: rtl/multiply_divide_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation codes,
// default latencies and the busy/idle state encoding.
package multiply_divide_unit_pkg;

  typedef enum logic [2:0] {
    mduOfNone  = 3'd0,
    mduOfMult  = 3'd1,
    mduOfMultu = 3'd2,
    mduOfDiv   = 3'd3,
    mduOfDivu  = 3'd4,
    mduOfMthi  = 3'd5,
    mduOfMtlo  = 3'd6,
    mduOfRsvd  = 3'd7
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/multiply_divide_unit_result_calc.sv
// Combinational result generator: produces the pending {HI,LO} value for a
// mult/div issue, plus a flag telling the top to keep HI/LO on divide by zero.
module mdu_result_calc
  import multiply_divide_unit_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [63:0] result_o,
  output logic        hold_o
);

  mdu_op_e     op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] safe_b, quo_u, rem_u;
  logic [31:0] mag_a, mag_b, mag_q, mag_r, quo_s, rem_s;

  always_comb begin
    op     = mdu_op_e'(op_i);
    prod_u = {32'b0, a_i} * {32'b0, b_i};
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};

    // Signed division via magnitudes keeps 0x80000000 / -1 well defined.
    safe_b = (b_i == '0) ? 32'd1 : b_i;
    quo_u  = a_i / safe_b;
    rem_u  = a_i % safe_b;
    mag_a  = a_i[31] ? -a_i : a_i;
    mag_b  = safe_b[31] ? -safe_b : safe_b;
    mag_q  = mag_a / mag_b;
    mag_r  = mag_a % mag_b;
    quo_s  = (a_i[31] ^ safe_b[31]) ? -mag_q : mag_q;
    rem_s  = a_i[31] ? -mag_r : mag_r;

    result_o = '0;
    hold_o   = 1'b0;
    case (op)
      mduOfMult:  result_o = prod_s;
      mduOfMultu: result_o = prod_u;
      mduOfDiv: begin
        result_o = {rem_s, quo_s};
        hold_o   = (b_i == '0);
      end
      mduOfDivu: begin
        result_o = {rem_u, quo_u};
        hold_o   = (b_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multiply_divide_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Mult/div results are held
// pending for a fixed busy window and committed on the last busy edge.
module multiply_divide_unit
  import multiply_divide_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mduInputA,
  input  logic [31:0] mduInputB,
  input  logic [2:0]  mduOperation,
  output logic        mduBusy,
  output logic [31:0] mduHi,
  output logic [31:0] mduLo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        hold_q, hold_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  mdu_op_e     op;
  logic [63:0] calc_result;
  logic        calc_hold;
  logic        last_cycle;

  mdu_result_calc u_calc (
    .a_i      (mduInputA),
    .b_i      (mduInputB),
    .op_i     (mduOperation),
    .result_o (calc_result),
    .hold_o   (calc_hold)
  );

  assign op         = mdu_op_e'(mduOperation);
  assign last_cycle = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hold_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (op inside {mduOfMult, mduOfMultu, mduOfDiv, mduOfDivu}) state_d = ST_BUSY;
      ST_BUSY: if (last_cycle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state; every operation is ignored while busy.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    hold_d = hold_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (state_q == ST_IDLE) begin
      case (op)
        mduOfMult, mduOfMultu: begin
          pend_d = calc_result;
          hold_d = 1'b0;
          cnt_d  = CW'(MULT_CYCLES);
        end
        mduOfDiv, mduOfDivu: begin
          pend_d = calc_result;
          hold_d = calc_hold;
          cnt_d  = CW'(DIV_CYCLES);
        end
        mduOfMthi: hi_d = mduInputA;
        mduOfMtlo: lo_d = mduInputA;
        default: ;
      endcase
    end else if (last_cycle) begin
      cnt_d = '0;
      if (!hold_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    mduBusy = (state_q == ST_BUSY);
    mduHi   = hi_q;
    mduLo   = lo_q;
  end

endmodule

// File: doc/multiply_divide_unit.md
Name: multiply_divide_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It consumes the same forwarded operand pair the ALU receives and owns the architectural HI/LO registers. It executes mult/multu/div/divu/mthi/mtlo and exposes HI and LO to the EX result mux for mfhi/mflo. It also exposes busy state so the hazard unit can stall MDU instructions in D.

Parameters:
MULT_CYCLES, 5, cycles mult/multu holds busy after issue; must be >=1
DIV_CYCLES, 10, cycles div/divu holds busy after issue; must be >=1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
mduInputA  input  32  rs operand (forwarded), dividend / multiplicand / mthi-mtlo source
mduInputB  input  32  rt operand (forwarded), divisor / multiplier
mduOperation  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
mduBusy  output  1  high while an issued mult/div is in flight
mduHi  output  32  architectural HI register
mduLo  output  32  architectural LO register

Behaviour:
- Reset (async, any time incl. mid-operation): mduHi=0, mduLo=0, mduBusy=0, counter=0, pending result discarded.
- Issue: mduOperation is sampled at the rising edge only when mduBusy=0. While mduBusy=1, every operation, including mthi/mtlo, is ignored. The hazard unit guarantees none arrives; the bench checks the ignore anyway.
- mult/multu issue edge: 64-bit product (signed / unsigned) latched into pending HI/LO; counter<=MULT_CYCLES; mduBusy<=1.
- div/divu issue edge: quotient->pending LO, remainder->pending HI; counter<=DIV_CYCLES; mduBusy<=1.
- Signed div: quotient truncates toward zero; remainder takes sign of dividend. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero (signed or unsigned): full DIV_CYCLES busy period; HI/LO unchanged at completion.
- Busy window: each edge with counter>1 decrements the counter. On the edge where counter==1: mduHi/mduLo<=pending, counter<=0, mduBusy<=0.
  - mduBusy is high for exactly N cycles after the issue edge (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible in the first cycle mduBusy is low.
  - HI/LO hold their old values throughout the busy window.
- mthi/mtlo (not busy): mduHi or mduLo <= mduInputA at that edge; visible next cycle; mduBusy unaffected.
- Back-to-back: an operation presented in the first cycle after busy drops is accepted at that edge.
- Outputs are purely registered; no combinational path from inputs to outputs.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Stall contract for the hazard unit: stall the D-stage MDU instruction if (E-stage mduOperation in 1..4) or mduBusy.

Decomposition:
- Shared defines include (alongside the ALU operation codes): mdu operation codes mduOfNone..mduOfMtlo, default cycle counts.
- Sub-module mdu_result_calc (combinational): operands + op -> 64-bit {hi,lo} pending value. It contains the signed/unsigned product, the quotient/remainder and the divide-by-zero hold flag.
- The top level holds the counter, busy, pending and HI/LO registers.

Test Plan:
- mult A=0xFFFFFFFF B=2 -> mduBusy high 5 cycles, HI/LO stay 0 during window; then HI=0xFFFFFFFF LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF B=2 -> after 5 cycles HI=0x00000001 LO=0xFFFFFFFE.
- div A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles; then LO=0xFFFFFFFD HI=0xFFFFFFFF.
- divu A=0xFFFFFFF9 B=2 -> LO=0x7FFFFFFC HI=0x00000001.
- Divide by zero:
  - mthi 0x1234, mtlo 0x5678, then div B=0 -> busy 10 cycles, HI=0x1234 LO=0x5678 afterwards.
  - 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
- Ignore and reset:
  - mtlo 0xAAAA issued during a mult busy window -> ignored; LO = product low word.
  - reset asserted mid-div (cycle 4) -> HI=LO=0, busy=0 immediately; no late write after reset release.
